// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants for the VGA sync path
//
// Purpose: default horizontal/vertical visible, porch and sync widths, the
// derived totals, the pixel clock divider and the counter width.
// Ports: none (package).

package vga_timing_pkg;

    localparam int DEF_CLK_DIV   = 4;     // 100 MHz system clock -> 25 MHz pixel rate

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Must hold both H_TOTAL-1 and V_TOTAL-1.
    localparam int DEF_CNT_W     = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping position counter with sync-window and visible decode
//
// Purpose: one display axis. Advances by one on each step, wraps to 0 when a
// step lands on TOTAL-1 or any larger value, and decodes the active-low sync
// window and the visible range from the registered count.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset, clears count
//   step     in   advance request (one-clk pulse)
//   count    out  W  current position
//   wrap     out  step while count is at or past TOTAL-1 (next step wraps)
//   at_last  out  count is exactly TOTAL-1
//   sync_n   out  low while SYNC_START <= count < SYNC_START+SYNC_LEN
//   visible  out  high while count < VISIBLE

module vga_axis_counter #(
    parameter int W          = 10,
    parameter int TOTAL      = 800,
    parameter int VISIBLE    = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         at_last,
    output logic         sync_n,
    output logic         visible
);

    // Compares are done at 32 bits so the sync window end may equal TOTAL
    // without overflowing a W-bit constant.
    logic [31:0] count_x;
    assign count_x = 32'(count);

    // ">=" rather than "==" so an out-of-range count recovers on its next step.
    logic past_last;
    assign past_last = (count_x >= 32'(TOTAL - 1));

    assign wrap    = step && past_last;
    assign at_last = (count_x == 32'(TOTAL - 1));
    assign sync_n  = !((count_x >= 32'(SYNC_START)) &&
                       (count_x <  32'(SYNC_START + SYNC_LEN)));
    assign visible = (count_x < 32'(VISIBLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (step) begin
            count <= past_last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_ctrl.sv
// rtl/vga_sync_ctrl.sv - VGA pixel tick, h/v counters and sync/visible decode
//
// Purpose: divides clk into a pixel tick, runs the horizontal counter on that
// tick and the vertical counter on the horizontal wrap, and decodes hsync,
// vsync, video_on, line_end and frame_end combinationally from the registered
// counters and En.
// Optional feature: define VGA_FRAME_COUNT_EN to add a 16-bit frame_count
// output that advances on every frame_end and wraps 0xFFFF -> 0.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   En           in   run enable; low freezes divider and counters
//   pix_tick     out  one-clk pulse per pixel period
//   hCount       out  CNT_W  pixel column 0..H_TOTAL-1
//   vCount       out  CNT_W  line 0..V_TOTAL-1
//   hsync        out  active-low horizontal sync
//   vsync        out  active-low vertical sync
//   video_on     out  high inside the visible area
//   line_end     out  pulse on the last tick of a line
//   frame_end    out  pulse on the last tick of a frame
//   frame_count  out  16  frames completed (VGA_FRAME_COUNT_EN only)

module vga_sync_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             En,
    output logic             pix_tick,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_end,
`ifdef VGA_FRAME_COUNT_EN
    output logic [15:0]      frame_count,
`endif
    output logic             frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Pixel divider: holds its phase while En is low so a resume finishes
    // the interrupted pixel period instead of restarting it.
    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (En) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign pix_tick = En && (div_cnt == DIV_LAST);

    logic h_wrap, h_last, h_sync_n, h_vis;
    logic v_wrap, v_last, v_sync_n, v_vis;

    vga_axis_counter #(
        .W          (CNT_W),
        .TOTAL      (H_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_VISIBLE + H_FP),
        .SYNC_LEN   (H_SYNC)
    ) u_h (
        .clk     (clk),
        .rst     (rst),
        .step    (pix_tick),
        .count   (hCount),
        .wrap    (h_wrap),
        .at_last (h_last),
        .sync_n  (h_sync_n),
        .visible (h_vis)
    );

    // Stepped by the horizontal wrap, so both counters change on the same
    // edge and (0, stale line) is never visible.
    vga_axis_counter #(
        .W          (CNT_W),
        .TOTAL      (V_TOTAL),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_VISIBLE + V_FP),
        .SYNC_LEN   (V_SYNC)
    ) u_v (
        .clk     (clk),
        .rst     (rst),
        .step    (h_wrap),
        .count   (vCount),
        .wrap    (v_wrap),
        .at_last (v_last),
        .sync_n  (v_sync_n),
        .visible (v_vis)
    );

    assign hsync     = h_sync_n;
    assign vsync     = v_sync_n;
    assign video_on  = h_vis && v_vis;
    assign line_end  = pix_tick && h_last;
    assign frame_end = line_end && v_last;

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
        end else if (frame_end) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

    // v_wrap only matters as the vertical counter's own step-and-wrap; the
    // frame boundary is reported through frame_end.
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb/tb_vga_sync_ctrl.sv - self-checking bench for vga_sync_ctrl (default and reduced timing)

module tb_vga_sync_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-timing instance
    logic       rst_def, en_def;
    logic       tick_def, hs_def, vs_def, von_def, le_def, fe_def;
    logic [9:0] hc_def, vc_def;
    logic [15:0] fc_def;

    // Reduced-timing instance: 16/2/3/3 x 10/2/2/2, CLK_DIV=2, 5-bit counters
    logic       rst_sml, en_sml;
    logic       tick_sml, hs_sml, vs_sml, von_sml, le_sml, fe_sml;
    logic [4:0] hc_sml, vc_sml;
    logic [15:0] fc_sml;

    vga_sync_ctrl u_def (
        .clk         (clk),
        .rst         (rst_def),
        .En          (en_def),
        .pix_tick    (tick_def),
        .hCount      (hc_def),
        .vCount      (vc_def),
        .hsync       (hs_def),
        .vsync       (vs_def),
        .video_on    (von_def),
        .line_end    (le_def),
`ifdef VGA_FRAME_COUNT_EN
        .frame_count (fc_def),
`endif
        .frame_end   (fe_def)
    );

    vga_sync_ctrl #(
        .CLK_DIV(2), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(2), .CNT_W(5)
    ) u_sml (
        .clk         (clk),
        .rst         (rst_sml),
        .En          (en_sml),
        .pix_tick    (tick_sml),
        .hCount      (hc_sml),
        .vCount      (vc_sml),
        .hsync       (hs_sml),
        .vsync       (vs_sml),
        .video_on    (von_sml),
        .line_end    (le_sml),
`ifdef VGA_FRAME_COUNT_EN
        .frame_count (fc_sml),
`endif
        .frame_end   (fe_sml)
    );

`ifndef VGA_FRAME_COUNT_EN
    assign fc_def = 16'd0;
    assign fc_sml = 16'd0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: everything follows from the number of enabled clocks
    // since the last reset.
    typedef struct packed {
        logic        tick, hsn, vsn, von, le, fe;
        logic [11:0] vc, hc;
    } exp_t;

    function automatic exp_t model(input longint e, input bit en, input int cd,
                                   input int hv, input int hf, input int hs, input int hb,
                                   input int vv, input int vf, input int vs, input int vb);
        exp_t   m;
        longint ht, vt, t, hc, vc, dv;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        dv = e % cd;
        t  = e / cd;
        hc = t % ht;
        vc = (t / ht) % vt;
        m.tick = en && (dv == cd - 1);
        m.hsn  = !(hc >= hv + hf && hc < hv + hf + hs);
        m.vsn  = !(vc >= vv + vf && vc < vv + vf + vs);
        m.von  = (hc < hv) && (vc < vv);
        m.le   = m.tick && (hc == ht - 1);
        m.fe   = m.le && (vc == vt - 1);
        m.hc   = 12'(hc);
        m.vc   = 12'(vc);
        return m;
    endfunction

    function automatic exp_t mdef(input longint e, input bit en);
        return model(e, en, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic exp_t msml(input longint e, input bit en);
        return model(e, en, 2, 16, 2, 3, 3, 10, 2, 2, 2);
    endfunction

    longint e_def, e_sml;

    always @(posedge clk or posedge rst_def)
        if (rst_def) e_def <= 0; else if (en_def) e_def <= e_def + 1;

    always @(posedge clk or posedge rst_sml)
        if (rst_sml) e_sml <= 0; else if (en_sml) e_sml <= e_sml + 1;

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        exp_t a, x;
        x = mdef(e_def, en_def);
        a = {tick_def, hs_def, vs_def, von_def, le_def, fe_def, 2'b00, vc_def, 2'b00, hc_def};
        chk("cycle_def", longint'(a), longint'(x));
        x = msml(e_sml, en_sml);
        a = {tick_sml, hs_sml, vs_sml, von_sml, le_sml, fe_sml, 7'd0, vc_sml, 7'd0, hc_sml};
        chk("cycle_sml", longint'(a), longint'(x));
`ifdef VGA_FRAME_COUNT_EN
        chk("fc_sml_cycle", fc_sml, (e_sml / (2 * 24 * 16)) % 65536);
`endif
    end

    initial begin
        exp_t m;
        int   cnt_a, cnt_b, cnt_c;
        bit   found;

        rst_def = 1'b1; en_def = 1'b0;
        rst_sml = 1'b1; en_sml = 1'b0;

        // Pin the model to hand-computed points of the default timing.
        m = mdef(4 * 656, 1'b1);       chk("pin_hsync_start", m.hsn, 0);
        chk("pin_hc_656", m.hc, 656);
        m = mdef(4 * 752, 1'b1);       chk("pin_hsync_end", m.hsn, 1);
        m = mdef(4 * 639, 1'b1);       chk("pin_von_639", m.von, 1);
        m = mdef(4 * 640, 1'b1);       chk("pin_von_640", m.von, 0);
        m = mdef(4 * (800 * 490) + 3, 1'b1);
        chk("pin_vsync_490", m.vsn, 0);
        chk("pin_tick", m.tick, 1);
        m = mdef(4 * (800 * 525 - 1) + 3, 1'b1);
        chk("pin_frame_end", m.fe, 1);
        m = mdef(4 * 800 * 525, 1'b1);
        chk("pin_wrap_hv", {m.vc, m.hc}, 0);

        repeat (3) @(posedge clk);
        #1 en_def = 1'b1;

        // Reset values while held in reset with En high
        @(negedge clk);
        chk("rst_pix_tick", tick_def, 0);
        chk("rst_hcount", hc_def, 0);
        chk("rst_vcount", vc_def, 0);
        chk("rst_hsync", hs_def, 1);
        chk("rst_vsync", vs_def, 1);
        chk("rst_video_on", von_def, 1);
        chk("rst_line_end", le_def, 0);
        chk("rst_frame_end", fe_def, 0);

        @(posedge clk);
        #1 rst_def = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("first_tick", tick_def, (k == 4) ? 1 : 0);
        end
        @(posedge clk); #1;
        chk("hcount_after_first", hc_def, 1);

        // Rest of line 0: hsync width and line_end position
        cnt_a = 0; cnt_b = 0; found = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (tick_def && !hs_def) cnt_a++;
            if (le_def) begin
                found = 1;
                chk("line_end_hcount", hc_def, 799);
                break;
            end
        end
        chk("line_end_seen", found, 1);
        chk("hsync_low_ticks", cnt_a, 96);
        @(posedge clk); #1;
        chk("wrap_hcount", hc_def, 0);
        chk("wrap_vcount", vc_def, 1);

        // Freeze at hCount=300 with the divider at phase 1
        found = 0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            if (hc_def == 300) begin found = 1; break; end
        end
        chk("reach_300", found, 1);
        @(posedge clk); #1 en_def = 1'b0;
        cnt_a = 0;
        repeat (37) begin
            @(negedge clk);
            if (tick_def) cnt_a++;
            @(posedge clk);
        end
        #1;
        chk("frozen_ticks", cnt_a, 0);
        chk("frozen_hcount", hc_def, 300);
        en_def = 1'b1;
        @(posedge clk); #1 chk("resume_edge1", hc_def, 300);
        @(posedge clk); #1 chk("resume_edge2", hc_def, 300);
        @(posedge clk); #1 chk("resume_edge3", hc_def, 301);

        // Asynchronous reset between edges
        @(posedge clk); #2 rst_def = 1'b1;
        #1;
        chk("async_rst_hcount", hc_def, 0);
        chk("async_rst_vcount", vc_def, 0);
        chk("async_rst_hsync", hs_def, 1);
        chk("async_rst_vsync", vs_def, 1);
        @(posedge clk); #1 en_def = 1'b0;

        // Reduced timing: full frame
        en_sml = 1'b1;
        @(posedge clk); #1 rst_sml = 1'b0;
        cnt_a = 0; cnt_b = 0; cnt_c = 0; found = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (tick_sml && !vs_sml) cnt_a++;
            if (tick_sml && von_sml) cnt_b++;
            if (le_sml) cnt_c++;
            if (fe_sml) begin
                found = 1;
                chk("frame_end_hc", hc_sml, 23);
                chk("frame_end_vc", vc_sml, 15);
                break;
            end
        end
        chk("frame_end_seen", found, 1);
        chk("vsync_low_ticks", cnt_a, 48);
        chk("visible_ticks", cnt_b, 160);
        chk("line_end_count", cnt_c, 16);
        @(posedge clk); #1;
        chk("frame_wrap_hv", {vc_sml, hc_sml}, 0);

        // Two more frames
        cnt_a = 0;
        for (int n = 0; n < 2000 && cnt_a < 2; n++) begin
            @(negedge clk);
            if (fe_sml) cnt_a++;
        end
        chk("extra_frames", cnt_a, 2);
        @(posedge clk); #1;
`ifdef VGA_FRAME_COUNT_EN
        chk("frame_count_3", fc_sml, 3);
`endif

        // Mid-frame asynchronous reset on the reduced instance
        found = 0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk); #1;
            if (vc_sml == 7 && hc_sml == 5) begin found = 1; break; end
        end
        chk("reach_7_5", found, 1);
        #2 rst_sml = 1'b1;
        #1;
        chk("sml_rst_hv", {vc_sml, hc_sml}, 0);
        chk("sml_rst_syncs", {hs_sml, vs_sml}, 2'b11);
        @(posedge clk); #1 rst_sml = 1'b0;
        repeat (60) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
